// File: rtl/bsg_fifo_rolly_replay_reader.sv
// Replay reader for a rollback-capable FIFO tracker: streams bursts, acks on ok, rolls back on fail.
// Optional response timeout enabled by defining BSG_FIFO_ROLLY_REPLAY_READER_TIMEOUT_EN.
module bsg_fifo_rolly_replay_reader #(
    parameter int width_p       = 32,
    parameter int max_burst_p   = 8,
    parameter int max_retries_p = 3,
    parameter int timeout_p     = 256
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    input  logic                                 start_v_i,
    output logic                                 start_ready_o,
    input  logic [$clog2(max_burst_p+1)-1:0]     burst_len_i,
    input  logic                                 fifo_empty_i,
    input  logic [width_p-1:0]                   fifo_data_i,
    output logic                                 fifo_read_o,
    output logic                                 fifo_rollback_o,
    output logic                                 fifo_ack_o,
    output logic [width_p-1:0]                   data_o,
    output logic                                 v_o,
    input  logic                                 ready_i,
    output logic                                 last_o,
    input  logic                                 resp_v_i,
    input  logic                                 resp_ok_i,
    output logic                                 done_o,
    output logic                                 drop_o,
    output logic [$clog2(max_retries_p+1)-1:0]   retry_cnt_o
);

    localparam int LW = $clog2(max_burst_p + 1);
    localparam int RW = $clog2(max_retries_p + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_WAIT
    } state_e;

    state_e          r_state, w_state_n;
    logic [LW-1:0]   r_len, w_len_n;
    logic [LW-1:0]   r_beat, w_beat_n;
    logic [RW-1:0]   r_retry, w_retry_n;
    logic            w_tmo;
    logic            w_fail;
    logic            w_hs;

    if (timeout_p < 1) begin : g_bad_timeout
        $error("timeout_p must be at least 1");
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
            r_len   <= '0;
            r_beat  <= '0;
            r_retry <= '0;
        end else begin
            r_state <= w_state_n;
            r_len   <= w_len_n;
            r_beat  <= w_beat_n;
            r_retry <= w_retry_n;
        end
    end

`ifdef BSG_FIFO_ROLLY_REPLAY_READER_TIMEOUT_EN
    localparam int TW = (timeout_p > 1) ? $clog2(timeout_p) : 1;
    logic [TW-1:0] r_tmo;

    // Held at zero outside WAIT so it restarts on every entry.
    always_ff @(posedge clk_i) begin
        if (reset_i || r_state != S_WAIT) begin
            r_tmo <= '0;
        end else if (!resp_v_i && r_tmo != TW'(timeout_p - 1)) begin
            r_tmo <= r_tmo + 1'b1;
        end
    end

    assign w_tmo = (r_state == S_WAIT) && (r_tmo == TW'(timeout_p - 1));
`else
    assign w_tmo = 1'b0;
`endif

    assign data_o      = fifo_data_i;
    assign retry_cnt_o = r_retry;

    always_comb begin
        w_state_n       = r_state;
        w_len_n         = r_len;
        w_beat_n        = r_beat;
        w_retry_n       = r_retry;
        start_ready_o   = 1'b0;
        v_o             = 1'b0;
        last_o          = 1'b0;
        fifo_read_o     = 1'b0;
        fifo_rollback_o = 1'b0;
        fifo_ack_o      = 1'b0;
        done_o          = 1'b0;
        drop_o          = 1'b0;
        w_hs            = 1'b0;
        w_fail          = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                start_ready_o = 1'b1;
                if (start_v_i && burst_len_i != '0
                    && burst_len_i <= LW'(max_burst_p)) begin
                    w_len_n   = burst_len_i;
                    w_beat_n  = '0;
                    w_retry_n = '0;
                    w_state_n = S_STREAM;
                end
            end
            S_STREAM: begin
                v_o         = ~fifo_empty_i;
                last_o      = v_o && (r_beat == r_len - LW'(1));
                w_hs        = v_o && ready_i;
                fifo_read_o = w_hs;
                if (w_hs && r_beat != {LW{1'b1}}) begin
                    w_beat_n = r_beat + 1'b1;
                end
                if (w_hs && last_o) begin
                    w_state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                // A real response in the same cycle beats the timeout.
                w_fail = resp_v_i ? ~resp_ok_i : w_tmo;
                if (resp_v_i && resp_ok_i) begin
                    fifo_ack_o = 1'b1;
                    done_o     = 1'b1;
                    w_state_n  = S_IDLE;
                end else if (w_fail && r_retry < RW'(max_retries_p)) begin
                    fifo_rollback_o = 1'b1;
                    w_retry_n       = r_retry + 1'b1;
                    w_beat_n        = '0;
                    w_state_n       = S_STREAM;
                end else if (w_fail) begin
                    fifo_ack_o = 1'b1;
                    drop_o     = 1'b1;
                    w_state_n  = S_IDLE;
                end
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!reset_i && start_v_i && start_ready_o) begin
            assert (burst_len_i <= LW'(max_burst_p))
                else $error("burst_len_i exceeds max_burst_p");
        end
        if (!reset_i) begin
            assert (32'(fifo_read_o) + 32'(fifo_rollback_o) + 32'(fifo_ack_o) <= 1)
                else $error("tracker controls overlap");
        end
    end
`endif

endmodule

// File: tb/tb_bsg_fifo_rolly_replay_reader.sv
// Randomized bench for bsg_fifo_rolly_replay_reader with a burst-level scoreboard.
// Models the tracker as pointers over a memory and predicts beats/responses per burst.
module tb_bsg_fifo_rolly_replay_reader;

    localparam int W  = 32;
    localparam int MB = 8;
    localparam int MR = 3;
    localparam int LW = $clog2(MB + 1);
    localparam int RW = $clog2(MR + 1);

    logic          clk = 1'b0;
    logic          reset_i;
    logic          start_v_i;
    logic          start_ready_o;
    logic [LW-1:0] burst_len_i;
    logic          fifo_empty_i;
    logic [W-1:0]  fifo_data_i;
    logic          fifo_read_o;
    logic          fifo_rollback_o;
    logic          fifo_ack_o;
    logic [W-1:0]  data_o;
    logic          v_o;
    logic          ready_i;
    logic          last_o;
    logic          resp_v_i;
    logic          resp_ok_i;
    logic          done_o;
    logic          drop_o;
    logic [RW-1:0] retry_cnt_o;

    always #5 clk = ~clk;

    bsg_fifo_rolly_replay_reader #(
        .width_p(W), .max_burst_p(MB), .max_retries_p(MR), .timeout_p(256)
    ) dut (
        .clk_i(clk), .reset_i(reset_i),
        .start_v_i(start_v_i), .start_ready_o(start_ready_o),
        .burst_len_i(burst_len_i),
        .fifo_empty_i(fifo_empty_i), .fifo_data_i(fifo_data_i),
        .fifo_read_o(fifo_read_o), .fifo_rollback_o(fifo_rollback_o),
        .fifo_ack_o(fifo_ack_o),
        .data_o(data_o), .v_o(v_o), .ready_i(ready_i), .last_o(last_o),
        .resp_v_i(resp_v_i), .resp_ok_i(resp_ok_i),
        .done_o(done_o), .drop_o(drop_o), .retry_cnt_o(retry_cnt_o)
    );

    // Tracker environment: committed write, speculative read, checkpoint.
    logic [W-1:0] mem [0:255];
    logic [31:0]  wp, rp, cp;
    logic         push;
    logic [W-1:0] push_data;

    assign fifo_empty_i = (rp == wp);
    assign fifo_data_i  = mem[rp[7:0]];

    always @(posedge clk) begin
        if (reset_i) begin
            wp <= 0; rp <= 0; cp <= 0;
        end else begin
            if (push) begin
                mem[wp[7:0]] <= push_data;
                wp <= wp + 1;
            end
            if (fifo_read_o) rp <= rp + 1;
            else if (fifo_rollback_o) rp <= cp;
            if (fifo_ack_o) cp <= rp;
        end
    end

    int n_chk = 0;
    int n_err = 0;
    logic [W-1:0] burst_data [$];
    int pushed;
    int committed;
    int retries;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (push) committed++;
        #1;
        push = 1'b0; start_v_i = 1'b0; resp_v_i = 1'b0; resp_ok_i = 1'b0;
    endtask

    task automatic do_push();
        push = 1'b1;
        push_data = $urandom;
        burst_data.push_back(push_data);
        pushed++;
    endtask

    task automatic new_burst();
        burst_data.delete();
        pushed = 0;
        committed = 0;
    endtask

    task automatic idle_cycle();
        resp_v_i = 1'($urandom % 2);
        resp_ok_i = 1'($urandom % 2);
        @(negedge clk);
        chk("idle_ready", start_ready_o, 1);
        chk("idle_v", v_o, 0);
        chk("idle_ack", fifo_ack_o, 0);
        chk("idle_rb", fifo_rollback_o, 0);
        step();
    endtask

    task automatic start(input int L);
        start_v_i = 1'b1;
        burst_len_i = LW'(L);
        @(negedge clk);
        chk("start_ready", start_ready_o, 1);
        chk("start_v", v_o, 0);
        step();
        retries = 0;
    endtask

    // rdy_mode: 0 always ready, 1 random, 2 toggling starting high
    task automatic stream(input int L, input int rdy_mode, input int stop_at);
        int beat = 0;
        int cyc = 0;
        bit avail;
        while (beat < stop_at && cyc < 300) begin
            case (rdy_mode)
                0: ready_i = 1'b1;
                1: ready_i = 1'($urandom % 2);
                default: ready_i = ~cyc[0];
            endcase
            if (pushed < L && ($urandom % 2) == 1) do_push();
            resp_v_i = 1'($urandom % 2);
            resp_ok_i = 1'($urandom % 2);
            @(negedge clk);
            avail = committed > beat;
            chk("v_o", v_o, avail);
            chk("read", fifo_read_o, avail && ready_i);
            chk("str_rb", fifo_rollback_o, 0);
            chk("str_ack", fifo_ack_o, 0);
            chk("str_ready", start_ready_o, 0);
            if (avail) begin
                chk("data", data_o, burst_data[beat]);
                chk("last", last_o, beat == L - 1);
            end
            if (avail && ready_i) beat++;
            step();
            cyc++;
        end
        if (beat < stop_at) chk("stream_budget", 0, 1);
    endtask

    task automatic wait_quiet(input int n);
        int pulses = 0;
        for (int i = 0; i < n; i++) begin
            ready_i = 1'($urandom % 2);
            @(negedge clk);
            if (v_o || fifo_rollback_o || fifo_ack_o || fifo_read_o
                || done_o || drop_o || start_ready_o) pulses++;
            step();
        end
        chk("wait_quiet", pulses, 0);
    endtask

    task automatic respond(input bit ok, output bit fin);
        resp_v_i = 1'b1;
        resp_ok_i = ok;
        ready_i = 1'($urandom % 2);
        @(negedge clk);
        chk("retry_cnt", retry_cnt_o, retries);
        chk("resp_read", fifo_read_o, 0);
        chk("resp_v", v_o, 0);
        if (ok) begin
            chk("ok_ack", fifo_ack_o, 1); chk("ok_done", done_o, 1);
            chk("ok_rb", fifo_rollback_o, 0); chk("ok_drop", drop_o, 0);
            fin = 1'b1;
        end else if (retries < MR) begin
            chk("fail_rb", fifo_rollback_o, 1); chk("fail_ack", fifo_ack_o, 0);
            chk("fail_done", done_o, 0); chk("fail_drop", drop_o, 0);
            retries++;
            fin = 1'b0;
        end else begin
            chk("drop_ack", fifo_ack_o, 1); chk("drop_drop", drop_o, 1);
            chk("drop_rb", fifo_rollback_o, 0); chk("drop_done", done_o, 0);
            fin = 1'b1;
        end
        step();
    endtask

    task automatic run_burst(input int L, input int nfail, input int npre,
                             input int rdy_mode, input int nwait);
        bit fin;
        int fails = 0;
        new_burst();
        for (int i = 0; i < npre; i++) begin
            do_push();
            idle_cycle();
        end
        start(L);
        fin = 1'b0;
        while (!fin) begin
            stream(L, rdy_mode, L);
            wait_quiet(nwait);
            respond(fails >= nfail, fin);
            fails++;
        end
        @(negedge clk);
        chk("post_ready", start_ready_o, 1);
        chk("post_done", done_o, 0);
        chk("post_drop", drop_o, 0);
        chk("post_retry", retry_cnt_o, retries);
        step();
    endtask

    initial begin
        reset_i = 1'b1; start_v_i = 0; burst_len_i = 0; push = 0; push_data = 0;
        ready_i = 0; resp_v_i = 0; resp_ok_i = 0;
        new_burst();
        step(); step();
        reset_i = 1'b0;
        @(negedge clk);
        chk("rst_ready", start_ready_o, 1);
        chk("rst_v", v_o, 0);
        chk("rst_ack", fifo_ack_o, 0);
        chk("rst_rb", fifo_rollback_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_drop", drop_o, 0);
        chk("rst_retry", retry_cnt_o, 0);
        step();

        run_burst(4, 0, 4, 0, 0);
        run_burst(4, 1, 4, 0, 1);
        run_burst(4, 4, 4, 0, 0);
        run_burst(4, 0, 2, 2, 0);

        // Zero-length request is accepted but ignored.
        new_burst();
        start(0);
        @(negedge clk);
        chk("len0_ready", start_ready_o, 1);
        chk("len0_v", v_o, 0);
        step();

        // Reset two beats into a burst.
        new_burst();
        for (int i = 0; i < 4; i++) begin
            do_push();
            idle_cycle();
        end
        start(4);
        stream(4, 0, 2);
        reset_i = 1'b1;
        ready_i = 1'b0;
        @(negedge clk);
        step();
        reset_i = 1'b0;
        new_burst();
        @(negedge clk);
        chk("mrst_v", v_o, 0);
        chk("mrst_ack", fifo_ack_o, 0);
        chk("mrst_rb", fifo_rollback_o, 0);
        chk("mrst_ready", start_ready_o, 1);
        chk("mrst_retry", retry_cnt_o, 0);
        step();

        // Without the timeout feature the response wait is unbounded.
        run_burst(3, 0, 3, 0, 1000);

        for (int b = 0; b < 40; b++) begin
            int L = $urandom_range(1, MB);
            run_burst(L, $urandom_range(0, 4), $urandom_range(0, L),
                      $urandom_range(0, 2), $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/bsg_fifo_rolly_replay_reader.md
Name: bsg_fifo_rolly_replay_reader

Overview:
- Consumer-side controller for a rollback-capable ("rolly") FIFO tracker.
- Drives the tracker's read, rollback and ack inputs.
- Streams a burst of FIFO entries to a downstream valid/ready sink, then waits for a per-burst ok/fail response.
- On ok it acks (frees the entries); on fail it rolls back and replays the same burst, up to a retry limit.

Parameters:
- width_p, 32: data width.
- max_burst_p, 8: maximum beats per burst.
- max_retries_p, 3: replays allowed before the burst is abandoned.
- timeout_p, 256: response timeout in cycles; used only with the optional feature.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  reset, synchronous, active-high.
- start_v_i  in  1  burst request.
- start_ready_o  out  1  high in IDLE only.
- burst_len_i  in  clog2(max_burst_p+1)  beats in burst; sampled when start_v_i & start_ready_o.
- fifo_empty_i  in  1  tracker empty (speculative read pointer equals committed write pointer).
- fifo_data_i  in  width_p  FIFO memory data at the current read pointer.
- fifo_read_o  out  1  advance speculative read pointer.
- fifo_rollback_o  out  1  restore read pointer to the checkpoint.
- fifo_ack_o  out  1  move the checkpoint to the read pointer, freeing entries.
- data_o  out  width_p  downstream data.
- v_o  out  1  downstream valid.
- ready_i  in  1  downstream ready.
- last_o  out  1  final beat of the burst.
- resp_v_i  in  1  burst response valid.
- resp_ok_i  in  1  1 = ok, 0 = fail.
- done_o  out  1  one-cycle pulse when a burst is acked after ok.
- drop_o  out  1  one-cycle pulse when a burst is abandoned after retries are exhausted.
- retry_cnt_o  out  clog2(max_retries_p+1)  retries used by the current burst.

Behaviour:
- States: IDLE, STREAM, WAIT_RESP.
- Registers: state, len_r, beat_r (same width as len_r), retry_r.
- Reset (synchronous): state=IDLE, len_r=beat_r=retry_r=0.
  - All pulse outputs are 0 and v_o=0.
  - start_ready_o=1 in the first cycle after reset.
- IDLE:
  - start_v_i=1 and burst_len_i in 1..max_burst_p: latch len, clear beat_r and retry_r, go to STREAM.
  - burst_len_i=0: request accepted but ignored; state stays IDLE.
  - burst_len_i>max_burst_p: illegal; flagged by a simulation assertion.
- STREAM:
  - v_o = ~fifo_empty_i; data_o = fifo_data_i combinationally (zero latency).
  - fifo_read_o = v_o & ready_i.
  - last_o = v_o & (beat_r == len_r-1).
  - On each handshake beat_r increments.
  - A handshake with last_o=1 goes to WAIT_RESP.
  - An empty FIFO mid-burst stalls: v_o=0 and no read.
- WAIT_RESP: v_o=0. Outputs below are combinational from resp_v_i in the same cycle.
  - resp_ok_i=1: fifo_ack_o=1, done_o=1, go to IDLE.
  - resp_ok_i=0 and retry_r<max_retries_p: fifo_rollback_o=1, retry_r+1, beat_r=0, go to STREAM. The replay starts the next cycle from the first entry of the burst.
  - resp_ok_i=0 and retry_r==max_retries_p: fifo_ack_o=1, drop_o=1, go to IDLE. Entries are freed and not replayed.
- resp_v_i outside WAIT_RESP is ignored.
- Output exclusivity:
  - fifo_read_o, fifo_rollback_o and fifo_ack_o are never high in the same cycle.
  - This block never drives the tracker's deq input; deq is tied to 0.
- Width rules: beat_r and retry_r saturate at their maxima and never wrap.
- Reset mid-burst:
  - Immediately returns to IDLE; no rollback or ack is issued.
  - The tracker is reset with the same reset_i.
- retry_cnt_o = retry_r.

Optional Feature:
- Macro: BSG_FIFO_ROLLY_REPLAY_READER_TIMEOUT_EN.
- Enabled:
  - A counter clears on entry to WAIT_RESP and increments each cycle without resp_v_i.
  - When it reaches timeout_p-1 with no response, that cycle is treated exactly as a fail response: rollback or drop per retry_r.
  - A resp_v_i in that same cycle takes priority over the timeout.
- Disabled:
  - No counter exists; WAIT_RESP waits indefinitely.
  - timeout_p is unused.

Test Plan:
- Clean burst: FIFO holds A0..A3, start len=4, ready_i=1.
  - Expect data_o A0,A1,A2,A3 over 4 consecutive cycles, last_o on A3.
  - resp ok -> fifo_ack_o=1 and done_o=1 for 1 cycle; start_ready_o=1 next cycle.
- Replay: same burst, resp fail once then ok.
  - Expect fifo_rollback_o pulse, A0..A3 re-streamed, retry_cnt_o=1, then ack.
- Exhaustion: max_retries_p=3, four fail responses.
  - Expect 3 rollbacks, then fifo_ack_o=1 with drop_o=1, and retry_cnt_o=3 at the drop.
- Stall/backpressure: FIFO holds 2 entries, len=4, ready_i toggling 1/0.
  - fifo_read_o only when v_o & ready_i; v_o=0 while empty.
  - After 2 more enqueues the burst completes with last_o on beat 4.
- Reset mid-STREAM after 2 beats:
  - Next cycle state is IDLE, v_o=0, no ack or rollback pulse, start_ready_o=1.
- Timeout (macro on, timeout_p=16): no response.
  - fifo_rollback_o asserted exactly 16 cycles after entering WAIT_RESP.
  - With the macro off, no pulse after 1000 cycles.
